// File: rtl/adder_pkg.sv
// Shared types and constants for the serial adder/subtractor block.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf
   );

   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_sum, out_cout, out_ovf
   );

endinterface

// File: rtl/full_adder.sv
// 1-bit full-adder cell from the adder library.
module full_adder (
   input  logic x,
   input  logic y,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = x ^ y ^ c_in;
   assign c_out = (x & y) | (c_in & (x ^ y));

endmodule

// File: rtl/serial_add_dp.sv
// Bit-serial datapath: operand shift registers, carry flop, result register and the adder cell.
module serial_add_dp
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic             step,
   input  logic             last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] shift_a_q;
   logic [WIDTH-1:0] shift_b_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             ovf_q;
   logic             cell_s;
   logic             cell_c;

   full_adder u_cell (
      .x     (shift_a_q[0]),
      .y     (shift_b_q[0]),
      .c_in  (carry_q),
      .s     (cell_s),
      .c_out (cell_c)
   );

   // Subtract is A + ~B + 1: invert B on load and seed the carry with the op bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a_q <= '0;
         shift_b_q <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (clr) begin
         carry_q <= 1'b0;
      end else if (load) begin
         shift_a_q <= a;
         shift_b_q <= b ^ {WIDTH{sub}};
         result_q  <= '0;
         carry_q   <= (sub == OP_SUB);
         ovf_q     <= 1'b0;
      end else if (step) begin
         result_q  <= {cell_s, result_q[WIDTH-1:1]};
         shift_a_q <= shift_a_q >> 1;
         shift_b_q <= shift_b_q >> 1;
         carry_q   <= cell_c;
         // Signed overflow is carry-into-MSB xor carry-out-of-MSB.
         if (last) begin
            ovf_q <= carry_q ^ cell_c;
         end
      end
   end

   assign sum  = result_q;
   assign cout = carry_q;
   assign ovf  = ovf_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: handshake FSM and bit counter around serial_add_dp.
module serial_add_ctrl
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   serial_add_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             load;
   logic             step;
   logic             last;

   assign load = in_ready_q & bus.in_valid & ~clr;
   assign step = (state_q == RUN) & ~clr;
   assign last = (cnt_q == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (clr) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  state_q    <= RUN;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
               end
            end
            RUN: begin
               if (last) begin
                  state_q     <= DONE;
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               // Re-arm only after the result is taken; no same-cycle bypass.
               if (bus.out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;

   serial_add_dp #(
      .WIDTH (WIDTH)
   ) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .load  (load),
      .step  (step),
      .last  (last),
      .a     (bus.in_a),
      .b     (bus.in_b),
      .sub   (bus.in_sub),
      .sum   (bus.out_sum),
      .cout  (bus.out_cout),
      .ovf   (bus.out_ovf)
   );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

   localparam int unsigned WIDTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic clr   = 1'b0;

   int checks = 0;
   int errors = 0;

   // {ovf, cout, sum}
   logic [9:0] exp_q[$];

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
      logic [8:0] full;
      logic [7:0] bb;
      logic       ovf;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
      if (sub) ovf = (a[7] != b[7]) && (full[7] != a[7]);
      else     ovf = (a[7] == b[7]) && (full[7] != a[7]);
      return {ovf, full[8], full[7:0]};
   endfunction

   // Present an operand pair, wait for acceptance, record the expected result.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
      int n = 0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 30) begin
         step();
         n++;
      end
      if (n >= 30) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready got %b want 1", bus.in_ready);
      end
      step();
      bus.in_valid = 1'b0;
      exp_q.push_back(model(a, b, sub));
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 30) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !== 12'h800) begin
         errors++;
         $display("FAIL reset ready/valid/sum/cout/ovf got %b/%b/%h/%b/%b want 1/0/00/0/0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
   endtask

   task automatic test_arith(input logic sub);
      logic [7:0] av[8];
      logic [7:0] bv[8];
      logic [9:0] exp;
      int         lat;
      if (!sub) begin
         av = '{8'h5A, 8'hFF, 8'h7F, 8'h00, 8'hC3, 8'h80, 8'h00, 8'h00};
         bv = '{8'h3C, 8'h01, 8'h01, 8'h00, 8'hA5, 8'h80, 8'h00, 8'h00};
      end else begin
         av = '{8'h10, 8'h80, 8'h00, 8'h7F, 8'h55, 8'hFF, 8'h00, 8'h00};
         bv = '{8'h20, 8'h01, 8'h00, 8'hFF, 8'h55, 8'h7F, 8'h00, 8'h00};
      end
      for (int i = 6; i < 8; i++) begin
         av[i] = 8'($urandom_range(255));
         bv[i] = 8'($urandom_range(255));
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(av[i], bv[i], sub);
         wait_result(lat);
         exp = exp_q.pop_front();
         checks++;
         if (lat !== 8) begin
            errors++;
            $display("FAIL arith%0d[%0d] latency got %0d want 8", sub, i, lat);
         end
         checks++;
         if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
            errors++;
            $display("FAIL arith%0d[%0d] a=%h b=%h ovf/cout/sum got %b/%b/%h want %b/%b/%h", sub, i,
                     av[i], bv[i], bus.out_ovf, bus.out_cout, bus.out_sum, exp[9], exp[8],
                     exp[7:0]);
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] exp;
      logic [9:0] snap;
      int         lat;
      bus.out_ready = 1'b0;
      send(8'h33, 8'h44, 1'b0);
      wait_result(lat);
      exp  = exp_q.pop_front();
      snap = {bus.out_ovf, bus.out_cout, bus.out_sum};
      checks++;
      if (snap !== exp) begin
         errors++;
         $display("FAIL bp_result got %h want %h", snap, exp);
      end
      // New operands offered while busy must be ignored.
      bus.in_a     = 8'hAA;
      bus.in_b     = 8'h11;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (!bus.out_valid || bus.in_ready ||
             {bus.out_ovf, bus.out_cout, bus.out_sum} !== snap) begin
            errors++;
            $display("FAIL bp_hold[%0d] valid/ready/res got %b/%b/%h want 1/0/%h", k,
                     bus.out_valid, bus.in_ready, {bus.out_ovf, bus.out_cout, bus.out_sum}, snap);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release valid/ready got %b/%b want 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp;
      int         last_acc = -1;
      int         accepts  = 0;
      int         results  = 0;
      bit         took;
      bus.out_ready = 1'b1;
      bus.in_a      = 8'h12;
      bus.in_b      = 8'h34;
      bus.in_sub    = 1'b0;
      bus.in_valid  = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         took = 1'b0;
         if (bus.in_ready) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc !== 10) begin
                  errors++;
                  $display("FAIL b2b_interval got %0d want 10", cyc - last_acc);
               end
            end
            last_acc = cyc;
            accepts++;
            took = 1'b1;
            exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
         end
         if (bus.out_valid) begin
            results++;
            exp = exp_q.pop_front();
            checks++;
            if ({bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
               errors++;
               $display("FAIL b2b_result[%0d] got %h want %h", results,
                        {bus.out_ovf, bus.out_cout, bus.out_sum}, exp);
            end
         end
         step();
         if (took) begin
            bus.in_a   = 8'($urandom_range(255));
            bus.in_b   = 8'($urandom_range(255));
            bus.in_sub = 1'($urandom_range(1));
         end
      end
      bus.in_valid = 1'b0;
      checks++;
      if (accepts !== 4 || results !== 4) begin
         errors++;
         $display("FAIL b2b_count accepts/results got %0d/%0d want 4/4", accepts, results);
      end
      exp_q.delete();
      step();
   endtask

   task automatic test_clr();
      logic [9:0] exp;
      int         lat;
      bit         seen = 1'b0;
      bus.out_ready = 1'b1;
      send(8'h5A, 8'h3C, 1'b0);
      repeat (4) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      void'(exp_q.pop_back());
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_abort valid/ready got %b/%b want 0/1", bus.out_valid, bus.in_ready);
      end
      for (int k = 0; k < 12; k++) begin
         if (bus.out_valid) seen = 1'b1;
         step();
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL clr_no_output out_valid got 1 want 0");
      end
      // clr beats a simultaneous operand offer.
      bus.in_a     = 8'h01;
      bus.in_b     = 8'h02;
      bus.in_valid = 1'b1;
      clr          = 1'b1;
      step();
      clr          = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_valid in_ready got %b want 1", bus.in_ready);
      end
      send(8'hA0, 8'h0F, 1'b1);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== 8 || {bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
         errors++;
         $display("FAIL clr_fresh lat/res got %0d/%h want 8/%h", lat,
                  {bus.out_ovf, bus.out_cout, bus.out_sum}, exp);
      end
      step();
   endtask

   task automatic test_async_reset();
      logic [9:0] exp;
      int         lat;
      bus.out_ready = 1'b1;
      send(8'hFF, 8'h0F, 1'b0);
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_back());
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf} !== 12'h800) begin
         errors++;
         $display("FAIL async_rst ready/valid/sum/cout/ovf got %b/%b/%h/%b/%b want 1/0/00/0/0",
                  bus.in_ready, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf);
      end
      repeat (2) step();
      rst_n = 1'b1;
      step();
      send(8'h64, 8'h64, 1'b0);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (lat !== 8 || {bus.out_ovf, bus.out_cout, bus.out_sum} !== exp) begin
         errors++;
         $display("FAIL async_fresh lat/res got %0d/%h want 8/%h", lat,
                  {bus.out_ovf, bus.out_cout, bus.out_sum}, exp);
      end
      step();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_arith(1'b0);
      test_arith(1'b1);
      test_backpressure();
      test_back_to_back();
      test_clr();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine for WIDTH-bit operands, built around a single 1-bit full-adder cell.
- Accepts an operand pair over a valid/ready handshake and feeds the pair through the cell one bit per clock, LSB first, holding the carry in a flop between bits.
- Returns the sum, carry-out and signed overflow over a second valid/ready handshake.
- Area-saving alternative to the ripple-carry adders in the adder library, for low-throughput datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; returns to IDLE and drops any operation in flight.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  result bits.
- out_cout  output  1  final carry-out; for subtract, 1 = no borrow.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All flops clear on rst_n low, regardless of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, carry=0, counter=0.
- FSM states: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: load shift_a=in_a, shift_b=in_b^{WIDTH{in_sub}}, carry=in_sub, cnt=0, clear the result register, then go to RUN.
- RUN, one bit per cycle:
  - Cell inputs: x=shift_a[0], y=shift_b[0], c_in=carry.
  - Shift the cell sum into the result MSB (result >> 1); shift shift_a and shift_b right; carry<=c_out; cnt<=cnt+1.
  - When cnt==WIDTH-1: capture the cell c_in as c_msb_in and go to DONE.
  - in_ready=0.
- DONE:
  - out_valid=1; out_sum=result; out_cout=carry; out_ovf=carry^c_msb_in.
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE, out_valid drops on the next cycle.
  - No bypass: a new operand pair is accepted no earlier than the cycle after the DONE->IDLE transition.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Arithmetic: modulo 2^WIDTH; counter wrap is never reached because RUN exits at WIDTH-1.
- in_valid during RUN/DONE: ignored (in_ready=0). Operand inputs need only be stable at the accepting edge.
- clr:
  - Has priority over every transition. State goes to IDLE, out_valid=0, carry=0, cnt=0.
  - Result and shift registers may keep stale data, but out_* must be qualified by out_valid.
  - clr asserted together with in_valid in IDLE: the operands are not accepted.
- rst_n low mid-RUN or mid-DONE: immediate return to reset values. The result is lost with no partial output.
- out_ready asserted outside DONE: no effect.

Decomposition:
- Shared package adder_pkg holds:
  - state enum IDLE/RUN/DONE (2-bit);
  - localparams OP_ADD=1'b0 and OP_SUB=1'b1.
- One natural sub-module, serial_add_dp:
  - holds the shift registers, carry flop, result register and the instantiated 1-bit full-adder cell;
  - takes load/step/clr controls from the FSM in serial_add_ctrl.
- The full-adder cell is reused unchanged from the adder library.

Test Plan (WIDTH=8):
1. Reset and idle: hold rst_n=0 for 3 cycles, then release -> in_ready=1, out_valid=0, all out_*=0.
2. Add:
   - stimulus: A=0x5A, B=0x3C, sub=0, out_ready=1;
   - response: out_valid exactly 8 cycles after accept, out_sum=0x96, out_cout=0, out_ovf=1.
3. Add with carry: A=0xFF, B=0x01, sub=0 -> out_sum=0x00, out_cout=1, out_ovf=0.
4. Subtract:
   - A=0x10, B=0x20, sub=1 -> out_sum=0xF0, out_cout=0 (borrow), out_ovf=0;
   - A=0x80, B=0x01, sub=1 -> out_sum=0x7F, out_cout=1, out_ovf=1.
5. Backpressure and flow control:
   - hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout;
   - assert out_ready -> IDLE next cycle;
   - back-to-back ops with in_valid held high -> accept every 10 cycles.
6. Abort and reset:
   - assert clr at RUN cycle 4 -> IDLE next cycle with no out_valid, then a fresh op returns the correct sum;
   - repeat with rst_n pulsed low mid-RUN -> asynchronous return to reset values.
